bbcd_seq: RTL
=============

Name: bbcd_seq

Overview:
Sequencer for the calculator's binary-to-BCD conversion path, using the shift-and-add-3 (double-dabble) algorithm. It captures a binary result on a START request and runs the iteration counter. It alternates add-3 adjust and shift phases, then presents packed BCD digits with a one-cycle DONE pulse. It sits between the ALU result register and the display/digit-select logic and owns the conversion datapath and its control.

Parameters:
N, 16, binary input width in bits (iterations per conversion).
D, 5, number of BCD output digits; must satisfy 10^D > 2^N (checked by elaboration-time assertion).

Ports:
CLK  input  1  system clock, rising-edge.
RST_N  input  1  asynchronous active-low reset.
START  input  1  conversion request; accepted only in IDLE.
CLR  input  1  synchronous abort; returns to IDLE from any state.
BIN  input  N  binary value; sampled on the accepting edge only.
BUSY  output  1  high while a conversion is in progress (ADJ or SHIFT).
DONE  output  1  one-cycle pulse when BCD holds a new result.
BCD  output  4*D  packed BCD, digit 0 in BCD[3:0]; held between conversions.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, BUSY=0, DONE=0, BCD=0, internal shift register=0, iteration counter=0.
- Internal state: shift register {digits[4D-1:0], bin[N-1:0]}; iteration counter of width clog2(N+1).
- States: IDLE, ADJ, SHIFT, DONE. BUSY = (state==ADJ || state==SHIFT). DONE = (state==DONE). Both are registered-state decodes.
- IDLE: if START=1 and CLR=0, load digits<=0, bin<=BIN, counter<=N, and go to ADJ. Otherwise stay.
- ADJ: in one cycle, for every digit, if the digit is >= 5 then digit <= digit + 3 (4-bit, no carry between digits). Go to SHIFT.
- SHIFT: shift the whole register left 1 (bin MSB enters digit 0 LSB, 0 enters bin LSB) and decrement the counter. If the decremented counter is 0, go to DONE and copy the post-shift digits into BCD on the same edge. Otherwise go to ADJ.
- DONE: held for exactly one cycle, then IDLE unconditionally. START during DONE is ignored. START still high in the following IDLE cycle is accepted there.
- Latency: the accepting edge is edge 0. DONE is high in the cycle following edge 2N, so for N=16 DONE is high 32 cycles after acceptance. The next START can be accepted 2N+2 edges after the previous one.
- START while BUSY or DONE: ignored, with no effect on BIN sampling or counter.
- BIN changes after the accepting edge have no effect on the result in flight.
- CLR=1: next edge forces IDLE from any state and clears the counter. BCD retains its last completed value. DONE is not pulsed. CLR has priority over START in the same cycle.
- Reset mid-conversion: immediate IDLE, BCD=0, no DONE pulse.
- BCD changes only on the SHIFT->DONE edge or at reset. Aborted conversions never corrupt BCD.
- The counter never underflows: it is only decremented in SHIFT, and SHIFT with counter 1 exits to DONE.

Test Plan:
- Reset, then START with BIN=16'd0 -> BUSY high for 32 cycles, DONE pulse for 1 cycle, BCD=20'h00000.
- BIN=16'd65535 -> BCD=20'h65535 with DONE exactly 32 cycles after the accepting edge. BIN=16'd255 -> BCD=20'h00255. BIN=16'd9 -> BCD=20'h00009.
- Start BIN=16'd1234, pulse START again with BIN=16'd4321 at cycle 10 -> second request ignored, BCD=20'h01234, single DONE pulse.
- Start BIN=16'd500, assert CLR at cycle 7 -> IDLE next cycle, BUSY=0, no DONE, BCD keeps previous 20'h01234. A new START is then accepted normally.
- Drive RST_N low at cycle 15 of a conversion -> BUSY=0, DONE=0, BCD=0 immediately, without waiting for a clock edge. After release, START with BIN=16'd42 -> BCD=20'h00042.
- Hold START high continuously with BIN=16'd100 -> a conversion every 34 edges, one DONE pulse each, BCD=20'h00100. Randomised sweep of BIN against a reference model -> all results match.

Source files
------------

// File: rtl/bbcd_seq.sv
// Binary-to-BCD conversion sequencer using shift-and-add-3 (double dabble).
// Captures BIN on an accepted START. Alternates adjust and shift phases N times,
// then latches the packed BCD digits and pulses DONE for one cycle.
module bbcd_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned D = 5
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    input  logic           CLR,
    input  logic [N-1:0]   BIN,
    output logic           BUSY,
    output logic           DONE,
    output logic [4*D-1:0] BCD
);

    localparam int unsigned W  = 4 * D + N;
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADJ   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // D digits must be able to hold the largest N-bit value.
    function automatic bit digits_ok();
        longint unsigned p10;
        p10 = 64'd1;
        for (int i = 0; i < int'(D); i++) begin
            p10 = p10 * 64'd10;
        end
        return p10 > (64'd1 << N);
    endfunction

    localparam bit DigitsOk = digits_ok();

    if (!DigitsOk) begin : g_bad_digits
        $error("bbcd_seq: D digits cannot represent all N-bit values");
    end

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   sr_q, sr_d;      // {digits, remaining binary bits}
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4*D-1:0] bcd_q, bcd_d;

    // Next-state and datapath update; CLR overrides everything except BCD hold.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sr_d    = {{(4 * D){1'b0}}, BIN};
                    cnt_d   = CW'(N);
                    state_d = ST_ADJ;
                end
            end
            ST_ADJ: begin
                for (int i = 0; i < int'(D); i++) begin
                    if (sr_q[N + 4 * i +: 4] >= 4'd5) begin
                        sr_d[N + 4 * i +: 4] = sr_q[N + 4 * i +: 4] + 4'd3;
                    end
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_d  = {sr_q[W-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = sr_q[W-2:N-1];
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADJ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (CLR) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bcd_d   = bcd_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        BUSY = (state_q == ST_ADJ) || (state_q == ST_SHIFT);
        DONE = (state_q == ST_DONE);
        BCD  = bcd_q;
    end

endmodule
